// File: rtl/apb_regfile_completer.sv
// APB completer: NUM_RW_REGS read/write words at offsets 0..NUM_RW_REGS-1,
// read-only transfer counter at offset 15, fixed WAIT_STATES before PREADY.
module apb_regfile_completer #(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned NUM_RW_REGS = 15
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [7:0]  PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);

   localparam logic [3:0] WS  = 4'(WAIT_STATES);
   localparam logic [5:0] NRW = 6'(NUM_RW_REGS);

   typedef enum logic {IDLE, ACCESS} state_e;

   state_e      state_q, state_d;
   logic [7:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [31:0] regs_q [NUM_RW_REGS];
   logic [31:0] xfer_cnt_q;

   logic [5:0]  k;
   logic        dec_err;
   logic        pready;
   logic        wr_en;
   logic [31:0] rdata;

   // Decode works only from the address latched in the setup cycle
   assign k       = addr_q[7:2];
   assign dec_err = (addr_q[1:0] != 2'b00) || (k > 6'd15) ||
                    (write_q && (k == 6'd15)) ||
                    ((k < 6'd15) && (k >= NRW));

   assign pready = (state_q == ACCESS) && PSEL && PENABLE && (wcnt_q == WS);
   assign wr_en  = pready && write_q && !dec_err;

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      write_d = write_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         IDLE: begin
            if (PSEL && !PENABLE) begin
               state_d = ACCESS;
               addr_d  = PADDR;
               write_d = PWRITE;
               wcnt_d  = '0;
            end
         end
         ACCESS: begin
            if (!PSEL) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else if (!PENABLE) begin
               // Fresh setup without completion: restart on the new address
               addr_d  = PADDR;
               write_d = PWRITE;
               wcnt_d  = '0;
            end else if (pready) begin
               state_d = IDLE;
               wcnt_d  = '0;
            end else begin
               wcnt_d  = wcnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wcnt_q  <= wcnt_d;
      end
   end

   for (genvar i = 0; i < int'(NUM_RW_REGS); i++) begin : g_reg
      always_ff @(posedge PCLK or negedge PRESET) begin
         if (!PRESET)                       regs_q[i] <= '0;
         else if (wr_en && (k == 6'(i)))    regs_q[i] <= PWDATA;
      end
   end

   // Every completion counts, errored or not; aborts never reach pready
   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET)     xfer_cnt_q <= '0;
      else if (pready) xfer_cnt_q <= xfer_cnt_q + 32'd1;
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < int'(NUM_RW_REGS); i++)
         if (k == 6'(i)) rdata = regs_q[i];
      if (k == 6'd15) rdata = xfer_cnt_q;
   end

   assign PREADY  = pready;
   assign PSLVERR = pready && dec_err;
   assign PRDATA  = (pready && !write_q && !dec_err) ? rdata : 32'd0;

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer: two instances (WAIT_STATES 0/8 regs and
// 1/15 regs) checked against an array-based model of the register map.
module tb_apb_regfile_completer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel [2];
   logic        penable [2];
   logic        pwrite [2];
   logic [7:0]  paddr [2];
   logic [31:0] pwdata [2];
   logic [31:0] prdata [2];
   logic        pready [2];
   logic        pslverr [2];

   always #5 clk = ~clk;

   apb_regfile_completer #(.WAIT_STATES(0), .NUM_RW_REGS(8)) u_dut0 (
      .PCLK(clk), .PRESET(rst_n), .PSEL(psel[0]), .PENABLE(penable[0]),
      .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]),
      .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

   apb_regfile_completer #(.WAIT_STATES(1), .NUM_RW_REGS(15)) u_dut1 (
      .PCLK(clk), .PRESET(rst_n), .PSEL(psel[1]), .PENABLE(penable[1]),
      .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]),
      .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

   int ncmp = 0;
   int nfail = 0;
   logic [31:0] mregs [2][16];
   logic [31:0] mcnt [2];

   function automatic int ws_of(int i);
      return (i == 0) ? 0 : 1;
   endfunction

   function automatic int nrw_of(int i);
      return (i == 0) ? 8 : 15;
   endfunction

   function automatic bit exp_err(int i, bit wr, logic [7:0] a);
      int kk;
      kk = int'(a) / 4;
      if (int'(a) % 4 != 0) return 1'b1;
      if (kk > 15)          return 1'b1;
      if (kk == 15)         return wr;
      return kk >= nrw_of(i);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(string tag, logic obs, logic exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mcnt[i] = '0;
         for (int j = 0; j < 16; j++) mregs[i][j] = '0;
      end
   endtask

   // Drive one cycle at the falling edge, leave outputs 1 time unit to settle
   task automatic drive(int i, bit sel, bit en, bit wr, logic [7:0] a, logic [31:0] wd);
      @(negedge clk);
      psel[i] = sel; penable[i] = en; pwrite[i] = wr; paddr[i] = a; pwdata[i] = wd;
      #1;
   endtask

   task automatic idle(int i);
      drive(i, 1'b0, 1'b0, 1'($urandom), 8'($urandom), $urandom);
      chkb("idle_ready", pready[i], 1'b0);
      chk("idle_rdata", prdata[i], 32'd0);
   endtask

   task automatic xfer(int i, bit wr, logic [7:0] a, logic [31:0] wd, string tag,
                       output logic [31:0] rd_obs);
      int waits;
      bit done;
      bit e;
      logic [31:0] er;
      e  = exp_err(i, wr, a);
      er = 32'd0;
      if (!wr && !e) er = (a[7:2] == 6'd15) ? mcnt[i] : mregs[i][a[5:2]];
      drive(i, 1'b1, 1'b0, wr, a, $urandom);
      chkb({tag, ":setup_ready"}, pready[i], 1'b0);
      waits = 0;
      done  = 1'b0;
      rd_obs = 'x;
      while (!done && waits < 20) begin
         // Address wiggles during ACCESS must be ignored
         drive(i, 1'b1, 1'b1, wr, 8'($urandom), wd);
         if (pready[i]) done = 1'b1;
         else begin
            chk({tag, ":wait_rdata"}, prdata[i], 32'd0);
            waits++;
         end
      end
      chk({tag, ":wait_cycles"}, 32'(waits), 32'(ws_of(i)));
      if (done) begin
         rd_obs = prdata[i];
         chkb({tag, ":slverr"}, pslverr[i], e);
         chk({tag, ":rdata"}, prdata[i], er);
         mcnt[i] = mcnt[i] + 32'd1;
         if (wr && !e) mregs[i][a[5:2]] = wd;
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  a;
      int          r;
      int          ii;
      for (int i = 0; i < 2; i++) begin
         psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
         paddr[i] = '0; pwdata[i] = '0;
      end
      model_reset();

      // Reset state
      #2;
      for (int i = 0; i < 2; i++) begin
         chkb("rst_ready", pready[i], 1'b0);
         chkb("rst_slverr", pslverr[i], 1'b0);
         chk("rst_rdata", prdata[i], 32'd0);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Zero wait states, back-to-back writes, counter read
      xfer(0, 1'b1, 8'h00, 32'h1111_0000, "b2b_w0", rd);
      xfer(0, 1'b1, 8'h08, 32'h2222_0008, "b2b_w8", rd);
      xfer(0, 1'b0, 8'h3C, 32'd0, "b2b_cnt", rd);
      chk("b2b_cnt_val", rd, 32'd2);
      xfer(0, 1'b0, 8'h3C, 32'd0, "b2b_cnt2", rd);
      chk("b2b_cnt_after", rd, 32'd3);
      // Boundary of the implemented register range
      xfer(0, 1'b1, 8'h1C, 32'hA5A5_0007, "top_rw", rd);
      xfer(0, 1'b1, 8'h20, 32'hBAD0_0008, "gap_w", rd);
      xfer(0, 1'b0, 8'h20, 32'd0, "gap_r", rd);
      xfer(0, 1'b0, 8'h1C, 32'd0, "top_r", rd);
      chk("top_r_val", rd, 32'hA5A5_0007);

      // One wait state write/read
      xfer(1, 1'b1, 8'h04, 32'hDEAD_BEEF, "ws1_w", rd);
      xfer(1, 1'b0, 8'h04, 32'd0, "ws1_r", rd);
      chk("ws1_r_val", rd, 32'hDEAD_BEEF);

      // Error accesses
      xfer(1, 1'b1, 8'h3C, 32'h5555_5555, "err_wcnt", rd);
      xfer(1, 1'b1, 8'h41, 32'h6666_6666, "err_hi", rd);
      xfer(1, 1'b0, 8'h06, 32'd0, "err_mis", rd);
      chk("err_mis_rdata", rd, 32'd0);
      xfer(1, 1'b0, 8'h3C, 32'd0, "err_cnt", rd);
      chk("err_cnt_val", rd, 32'd5);
      xfer(1, 1'b0, 8'h04, 32'd0, "err_keep", rd);
      chk("err_keep_val", rd, 32'hDEAD_BEEF);

      // Abort: PSEL drops during the wait state
      drive(1, 1'b1, 1'b0, 1'b1, 8'h10, 32'h1234_5678);
      drive(1, 1'b1, 1'b1, 1'b1, 8'h10, 32'h1234_5678);
      chkb("abort_wait_ready", pready[1], 1'b0);
      drive(1, 1'b0, 1'b0, 1'b1, 8'h10, 32'h1234_5678);
      chkb("abort_drop_ready", pready[1], 1'b0);
      xfer(1, 1'b0, 8'h10, 32'd0, "abort_reg", rd);
      chk("abort_reg_val", rd, 32'd0);
      xfer(1, 1'b0, 8'h3C, 32'd0, "abort_cnt", rd);

      // New setup in ACCESS restarts the wait count on the new address
      drive(1, 1'b1, 1'b0, 1'b1, 8'h14, 32'h0);
      drive(1, 1'b1, 1'b1, 1'b1, 8'h14, 32'h7777_0014);
      chkb("resetup_a_wait", pready[1], 1'b0);
      drive(1, 1'b1, 1'b0, 1'b1, 8'h18, 32'h0);
      chkb("resetup_setup", pready[1], 1'b0);
      drive(1, 1'b1, 1'b1, 1'b1, 8'h99, 32'h8888_0018);
      chkb("resetup_b_wait", pready[1], 1'b0);
      drive(1, 1'b1, 1'b1, 1'b1, 8'h99, 32'h8888_0018);
      chkb("resetup_b_ready", pready[1], 1'b1);
      chkb("resetup_b_err", pslverr[1], 1'b0);
      mcnt[1] = mcnt[1] + 32'd1;
      mregs[1][6] = 32'h8888_0018;
      xfer(1, 1'b0, 8'h14, 32'd0, "resetup_a_r", rd);
      chk("resetup_a_val", rd, 32'd0);
      xfer(1, 1'b0, 8'h18, 32'd0, "resetup_b_r", rd);
      chk("resetup_b_val", rd, 32'h8888_0018);

      // Counter wrap
      @(negedge clk);
      force u_dut1.xfer_cnt_q = 32'hFFFF_FFFF;
      #1;
      release u_dut1.xfer_cnt_q;
      mcnt[1] = 32'hFFFF_FFFF;
      xfer(1, 1'b0, 8'h3C, 32'd0, "wrap_pre", rd);
      chk("wrap_pre_val", rd, 32'hFFFF_FFFF);
      xfer(1, 1'b0, 8'h3C, 32'd0, "wrap_post", rd);
      chk("wrap_post_val", rd, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 120; n++) begin
         ii = int'($urandom_range(0, 1));
         r  = int'($urandom_range(0, 7));
         if (r <= 4)      a = {4'($urandom_range(0, 15)), 2'b00} << 0;
         else if (r == 5) a = 8'h3C;
         else if (r == 6) a = 8'($urandom);
         else             a = {6'($urandom_range(16, 63)), 2'b00};
         if (r <= 4) a = {2'b00, a[5:0]} << 2 >> 2 << 2;
         xfer(ii, 1'($urandom), a, $urandom, "rand", rd);
         if ($urandom_range(0, 2) == 0) idle(ii);
      end

      // Asynchronous reset in the middle of a completing access
      drive(0, 1'b1, 1'b0, 1'b1, 8'h04, 32'hCAFE_F00D);
      drive(0, 1'b1, 1'b1, 1'b1, 8'h04, 32'hCAFE_F00D);
      chkb("arst_ready_before", pready[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chkb("arst_ready_now", pready[0], 1'b0);
      chkb("arst_slverr_now", pslverr[0], 1'b0);
      chk("arst_rdata_now", prdata[0], 32'd0);
      model_reset();
      drive(0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      drive(1, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      #2 rst_n = 1'b1;
      for (int j = 0; j < 16; j++) begin
         if (j < 8 || j == 15) begin
            xfer(0, 1'b0, 8'(j * 4), 32'd0, "post_rst0", rd);
            if (j < 8) chk("post_rst0_zero", rd, 32'd0);
         end
         xfer(1, 1'b0, 8'(j * 4), 32'd0, "post_rst1", rd);
      end
      idle(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/apb_regfile_completer.md
APB_REGFILE_COMPLETER -- requirements
Module: apb_regfile_completer

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning number of ACCESS-phase cycles with PREADY low before completion (legal range 0..15).
REQ-002 SHALL have parameter NUM_RW_REGS, default 15, meaning read/write 32-bit registers at word offsets 0..NUM_RW_REGS-1.
REQ-003 SHALL have ports, clock and reset first:
- PCLK  input  1  single clock, rising edge.
- PRESET  input  1  asynchronous active-low reset.
- PSEL  input  1  completer select.
- PENABLE  input  1  access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  8  byte address.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  transfer error, valid only with PREADY.
REQ-004 SHALL use one clock, PCLK; reset PRESET SHALL be asynchronous and active-low.

Function
REQ-005 SHALL implement state machine IDLE, ACCESS.
- IDLE -> ACCESS on PSEL=1, PENABLE=0 (setup cycle).
- Other input combinations in IDLE: stay in IDLE.
REQ-006 SHALL capture PADDR and PWRITE on the setup edge; PADDR changes during ACCESS SHALL be ignored. PWDATA SHALL be sampled at the completing edge.
REQ-007 In ACCESS, wait counter SHALL start at 0 and increment each cycle while PREADY=0.
REQ-008 PREADY SHALL be 1 iff state=ACCESS and PSEL=1 and PENABLE=1 and counter=WAIT_STATES.
- WAIT_STATES=0: PREADY high in the first access cycle.
- WAIT_STATES=N: PREADY high in access cycle N+1.
REQ-009 Transfer completes on the edge where PSEL=PENABLE=PREADY=1; state SHALL then return to IDLE. A back-to-back setup in the next cycle SHALL be accepted.
REQ-010 Address decode, using captured address:
- Offset k = PADDR[7:2].
- Error when PADDR[1:0]!=0.
- Error when k>15.
- Error on a write to k=15.
- Error when NUM_RW_REGS<=k<15.
REQ-011 Register k=15 SHALL be a read-only transfer counter.
- Increments by 1 on every completed transfer, including errored ones.
- Wraps 0xFFFFFFFF -> 0.
REQ-012 A non-error write SHALL update register k with PWDATA at the completing edge; an errored write SHALL modify no register.
REQ-013 PRDATA SHALL equal register k when PREADY=1, PWRITE=0 and no error; it SHALL be 0 in all other cycles.
- A read of k=15 SHALL return the counter value before that transfer's increment.
REQ-014 PSLVERR SHALL equal the decode error when PREADY=1, and 0 otherwise.
REQ-015 If PSEL falls in ACCESS before completion, the FSM SHALL abort to IDLE. An abort SHALL cause no register write and no counter increment.
REQ-016 If PSEL=1 and PENABLE=0 occurs in ACCESS (new setup without completion), the FSM SHALL treat it as an abort followed by a new setup. It SHALL recapture the address and remain in ACCESS with counter=0.

Reset
REQ-017 While PRESET=0, outputs SHALL be driven immediately, independent of PCLK:
- PREADY=0, PSLVERR=0, PRDATA=0.
- State=IDLE, wait counter=0.
- All registers and the transfer counter = 0.
REQ-018 Reset asserted mid-transfer SHALL abort it with no register update; operation SHALL resume on the first setup after PRESET deasserts.

Verification
REQ-019 WAIT_STATES=1: write 0xDEADBEEF to 0x04, then read 0x04 -> PREADY low in 1 access cycle, high in the 2nd; read PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-020 WAIT_STATES=0: back-to-back writes to 0x00 and 0x08, then read 0x3C -> each PREADY high in the first access cycle; read returns 2, and the counter is 3 afterwards.
REQ-021 Errors: write to 0x3C, write to 0x41, read from 0x06 -> PSLVERR=1 with PREADY; no register changes; PRDATA=0; counter +3.
REQ-022 Abort: PSEL dropped during wait on a write of 0x12345678 to 0x10 -> register 4 unchanged, counter unchanged, PREADY never high.
REQ-023 Reset: PRESET pulled low mid-ACCESS, asynchronously to PCLK -> PREADY=0 at once; all registers read 0 after release.
REQ-024 Counter wrap: preload by forcing the counter to 0xFFFFFFFF, then run one transfer -> counter reads 0.
